nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 91 +++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - 8-bit adder computed as two registered nibble steps
// Operands are captured on acceptance so later input changes cannot disturb the sum.
module nibble_serial_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [3:0] Hi,
  output logic [3:0] Lo,
  output logic       Cout,
  output logic       V,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [7:0] a_q, b_q;
  logic       cin_q;
  logic       nib_c;
  logic [4:0] lo_sum;
  logic [4:0] hi_sum;

  assign lo_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, cin_q};
  assign hi_sum = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'b0000, nib_c};

  always_comb begin
    state_nx = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = LOW;
      LOW: begin
        Busy     = 1'b1;
        state_nx = HIGH;
      end
      HIGH: begin
        Busy     = 1'b1;
        state_nx = FIN;
      end
      FIN: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      cin_q <= 1'b0;
      nib_c <= 1'b0;
      Hi    <= 4'h0;
      Lo    <= 4'h0;
      Cout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_q   <= A;
          b_q   <= B;
          cin_q <= Cin;
        end
        LOW: begin
          Lo    <= lo_sum[3:0];
          nib_c <= lo_sum[4];
        end
        HIGH: begin
          Hi   <= hi_sum[3:0];
          Cout <= hi_sum[4];
          // Overflow: like-signed operands producing a result of the other sign.
          V    <= (a_q[7] == b_q[7]) && (hi_sum[3] != a_q[7]);
        end
        default: ;
      endcase
    end
  end

endmodule
